npu_mac_array: RTL
==================

NPU_MAC_ARRAY -- requirements
Module: npu_mac_array

Interface
REQ-001 SHALL have parameter LANES, default 4: number of parallel MAC/ReLU lanes (1..8).
REQ-002 SHALL have parameter DATA_W, default 8: signed operand and bias width.
REQ-003 SHALL have parameter ACC_W, default 16: signed accumulator width, even, at least 2*DATA_W.
REQ-004 SHALL have port CLKEXT, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST_GLO, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port START, input, 1: job request; sampled only in IDLE.
REQ-007 SHALL have port K_LEN, input, 8: accumulate beat count; sampled with START.
REQ-008 SHALL have port BYPASS_RELU, input, LANES: per-lane ReLU bypass; sampled with START.
REQ-009 SHALL have port BIAS_IN, input, LANES*DATA_W: per-lane signed bias; lane i is bits [i*DATA_W +: DATA_W]; sampled with START.
REQ-010 SHALL have ports A_IN and B_IN, input, LANES*DATA_W each: per-lane signed operands.
REQ-011 SHALL have ports IN_VALID (input, 1) and IN_READY (output, 1): operand handshake.
REQ-012 SHALL have ports OUT_DATA (output, 8), OUT_VALID (output, 1) and OUT_READY (input, 1): byte-stream handshake.
REQ-013 SHALL have port BUSY, output, 1: high in every state except IDLE.
REQ-014 SHALL have port DONE, output, 1: one-cycle pulse at job end.
REQ-015 SHALL have ports MAX_INDEX (output, 8) and MAX_VALUE (output, ACC_W): argmax over the post-ReLU lane results.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, ACT, SHIFT and FINISH.
- IDLE -> ACCUM on START, or IDLE -> ACT if K_LEN=0.
REQ-017 SHALL, on the START cycle, load each lane accumulator with the sign-extended BIAS_IN of that lane.
REQ-018 SHALL assert IN_READY only in ACCUM; a beat is IN_VALID&IN_READY; IN_VALID low stalls with no change.
REQ-019 SHALL, per beat, add the full-precision signed product A*B of each lane to its accumulator.
- The sum saturates to the signed ACC_W range: no wrap; saturation is sticky per addition only.
REQ-020 SHALL leave ACCUM for ACT on the K_LEN-th beat; K_LEN=0 yields result = bias.
REQ-021 SHALL, in ACT (one cycle), register the ReLU of each lane: negative -> 0 unless that lane's BYPASS_RELU bit is 1.
- The same cycle SHALL update MAX_INDEX and MAX_VALUE (signed compare; ties -> lowest index).
REQ-022 SHALL, in SHIFT, hold OUT_VALID high and emit 2*LANES bytes.
- Order: lane LANES-1 first, down to lane 0; within a lane, high byte then low byte, (ACC_W/2)-bit halves truncated/zero-extended to 8.
REQ-023 SHALL advance the byte pointer only on OUT_VALID&OUT_READY; OUT_DATA stays stable while stalled.
REQ-024 SHALL go to FINISH after the last byte is accepted, pulse DONE for one cycle, then return to IDLE.
REQ-025 SHALL ignore START while BUSY; MAX_INDEX/MAX_VALUE hold until the next ACT.
REQ-026 SHALL, from IDLE with K_LEN=1 and no stalls, produce the first OUT_VALID 3 cycles after START.

Reset
REQ-027 SHALL, on RST_GLO high at any state including mid-job, force:
- state IDLE, all accumulators and ReLU registers 0, byte pointer 0;
- IN_READY, OUT_VALID, BUSY, DONE = 0; OUT_DATA, MAX_INDEX, MAX_VALUE = 0.
REQ-028 SHALL give RST_GLO priority over START and over any handshake in the same cycle.

Structure
REQ-029 SHALL place the FSM state enum and the default LANES/DATA_W/ACC_W constants in shared package npu_pkg.
REQ-030 SHALL instantiate one sub-module mac_lane per lane: bias load, saturating MAC, ReLU/bypass register.

Verification
REQ-031 SHALL cover: LANES=4, bias all 1, K_LEN=2, A=3, B=4 per lane -> each lane 25; 8 bytes 00,19 x4; MAX_INDEX 0.
REQ-032 SHALL cover: lane2 A=-100, B=100, K_LEN=4, bias 0 -> saturates to -32768; ReLU -> 0000; with BYPASS_RELU[2]=1 -> bytes 80,00.
REQ-033 SHALL cover: K_LEN=0, biases 5,-3,9,9 -> results 5,0,9,9; MAX_INDEX 2, MAX_VALUE 9; no IN_READY pulse.
REQ-034 SHALL cover: OUT_READY low for 5 cycles at byte 3 -> OUT_DATA stable; no byte lost or duplicated; DONE once after byte 8.
REQ-035 SHALL cover: RST_GLO for one cycle mid-ACCUM -> next cycle IDLE, all outputs 0; a START two cycles later runs a clean job.
REQ-036 SHALL cover: START held during SHIFT -> ignored; exactly one DONE; BUSY low only after FINISH.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared constants and FSM state encoding for the NPU MAC array.
package npu_pkg;
  localparam int DEF_LANES  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_ACT    = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;
endpackage

// File: rtl/npu_mac_array_if.sv
// Operand input and byte-stream output handshake bundle of the MAC array.
interface npu_mac_array_if #(
  parameter int LANES  = npu_pkg::DEF_LANES,
  parameter int DATA_W = npu_pkg::DEF_DATA_W
);
  logic [LANES*DATA_W-1:0] A_IN;
  logic [LANES*DATA_W-1:0] B_IN;
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [7:0]              OUT_DATA;
  logic                    OUT_VALID;
  logic                    OUT_READY;

  modport master (
    output A_IN, B_IN, IN_VALID, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_VALID
  );

  modport slave (
    input  A_IN, B_IN, IN_VALID, OUT_READY,
    output IN_READY, OUT_DATA, OUT_VALID
  );
endinterface

// File: rtl/mac_lane.sv
// One lane: bias load, saturating signed multiply-accumulate, ReLU/bypass result register.
module mac_lane import npu_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_bias,
  input  logic              i_beat,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_act,
  input  logic              i_bypass,
  output logic [ACC_W-1:0]  o_act,
  output logic [ACC_W-1:0]  o_res
);
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_res;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W:0]      w_sum;
  logic [ACC_W-1:0]    w_sat;

  assign w_prod = $signed(i_a) * $signed(i_b);
  // One guard bit is enough: |product| never exceeds a quarter of the accumulator range.
  assign w_sum  = {r_acc[ACC_W-1], r_acc}
                + {{(ACC_W+1-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};

  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1]) w_sat = w_sum[ACC_W] ? MIN_V : MAX_V;
  end

  assign o_act = (r_acc[ACC_W-1] && !i_bypass) ? '0 : r_acc;
  assign o_res = r_res;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_res <= '0;
    end else begin
      if (i_load)      r_acc <= {{(ACC_W-DATA_W){i_bias[DATA_W-1]}}, i_bias};
      else if (i_beat) r_acc <= w_sat;
      if (i_act)       r_res <= o_act;
    end
  end
endmodule

// File: rtl/npu_mac_array.sv
// Multi-lane MAC/ReLU job engine: accumulate K beats, activate, then stream results as bytes.
module npu_mac_array import npu_pkg::*; #(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                    CLKEXT,
  input  logic                    RST_GLO,
  input  logic                    START,
  input  logic [7:0]              K_LEN,
  input  logic [LANES-1:0]        BYPASS_RELU,
  input  logic [LANES*DATA_W-1:0] BIAS_IN,
  npu_mac_array_if.slave          bus,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [7:0]              MAX_INDEX,
  output logic [ACC_W-1:0]        MAX_VALUE,
  output state_t                  DBG_STATE
);
  localparam int NBYTES = 2 * LANES;
  localparam int PTR_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NBYTES - 1);

  state_t           r_state;
  logic [7:0]       r_rem;
  logic [PTR_W-1:0] r_ptr;
  logic [LANES-1:0] r_bypass;
  logic             r_in_ready, r_out_valid, r_busy, r_done;
  logic [7:0]       r_max_idx;
  logic [ACC_W-1:0] r_max_val;

  logic             w_load, w_beat, w_act, w_take;
  logic [ACC_W-1:0] w_act_v [LANES];
  logic [ACC_W-1:0] w_res   [LANES];
  logic [7:0]       w_bytes [NBYTES];
  logic [7:0]       w_best_idx;
  logic [ACC_W-1:0] w_best_val;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // an offered beat or byte stays unchanged until it is taken.
  assign w_load = (r_state == ST_IDLE) && START;
  assign w_beat = bus.IN_VALID && r_in_ready;
  assign w_act  = (r_state == ST_ACT);
  assign w_take = r_out_valid && bus.OUT_READY;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .i_clk    (CLKEXT),
      .i_rst    (RST_GLO),
      .i_load   (w_load),
      .i_bias   (BIAS_IN[g*DATA_W +: DATA_W]),
      .i_beat   (w_beat),
      .i_a      (bus.A_IN[g*DATA_W +: DATA_W]),
      .i_b      (bus.B_IN[g*DATA_W +: DATA_W]),
      .i_act    (w_act),
      .i_bypass (r_bypass[g]),
      .o_act    (w_act_v[g]),
      .o_res    (w_res[g])
    );
    // Highest lane leaves first, high half before low half.
    assign w_bytes[2*(LANES-1-g)]   = 8'(w_res[g][ACC_W-1:ACC_W/2]);
    assign w_bytes[2*(LANES-1-g)+1] = 8'(w_res[g][ACC_W/2-1:0]);
  end

  always_comb begin
    w_best_idx = 8'd0;
    w_best_val = w_act_v[0];
    for (int i = 1; i < LANES; i++) begin
      if ($signed(w_act_v[i]) > $signed(w_best_val)) begin
        w_best_val = w_act_v[i];
        w_best_idx = 8'(i);
      end
    end
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_GLO) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_ptr       <= '0;
      r_bypass    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_max_idx   <= '0;
      r_max_val   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (START) begin
          r_bypass <= BYPASS_RELU;
          r_rem    <= K_LEN;
          r_busy   <= 1'b1;
          if (K_LEN == 8'd0) begin
            r_state <= ST_ACT;
          end else begin
            r_state    <= ST_ACCUM;
            r_in_ready <= 1'b1;
          end
        end
        ST_ACCUM: if (w_beat) begin
          r_rem <= r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            r_state    <= ST_ACT;
            r_in_ready <= 1'b0;
          end
        end
        ST_ACT: begin
          r_state     <= ST_SHIFT;
          r_ptr       <= '0;
          r_out_valid <= 1'b1;
          r_max_idx   <= w_best_idx;
          r_max_val   <= w_best_val;
        end
        ST_SHIFT: if (w_take) begin
          if (r_ptr == LAST) begin
            r_state     <= ST_FINISH;
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = r_in_ready;
  assign bus.OUT_VALID = r_out_valid;
  assign bus.OUT_DATA  = r_out_valid ? w_bytes[r_ptr] : 8'h00;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign MAX_INDEX     = r_max_idx;
  assign MAX_VALUE     = r_max_val;
  assign DBG_STATE     = r_state;
endmodule
